counter_timer_arbiter: RTL
==========================

# counter_timer_arbiter

Controller that owns a CNT_W-bit down-counter and shares it between two requesters, each asking for a timed interval of a programmable length. It arbitrates round-robin, loads the counter with the winner's length, runs it to zero, then signals completion to that requester. It sits between request sources and the counter datapath and replaces free-running counter use wherever a bounded, exclusive interval is needed.

## Interface
- CNT_W, 4, counter and length width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester interval request, level; bit i = requester i
- len0  in  CNT_W  interval length for requester 0, sampled on grant
- len1  in  CNT_W  interval length for requester 1, sampled on grant
- abort  in  1  terminate the current interval early
- gnt  out  2  one-hot grant, registered
- busy  out  1  high whenever state != IDLE
- count  out  CNT_W  remaining cycles of current interval
- done  out  2  one-cycle completion pulse to the granted requester
- aborted  out  1  qualifies done: interval ended by abort

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset (rst low, asynchronous): gnt=0, busy=0, count=0, done=0, aborted=0, last-served pointer=1 (requester 0 has priority first).
- IDLE: if req==0, stay. Otherwise pick winner: single requester wins; both requesting -> requester != last-served wins. On that edge: gnt<=onehot(winner), count<=len of winner. Next state RUN if len!=0, else DONE.
- RUN: count decrements by 1 each cycle. When count==1, next cycle count=0 and state DONE. RUN therefore lasts exactly len cycles.
- abort high in RUN: next cycle state DONE, count<=0, aborted<=1. abort in IDLE or DONE ignored.
- req[i] deasserted during RUN: ignored; interval completes normally. len inputs changing during RUN: ignored (sampled only at grant).
- DONE: done[winner]=1, gnt held, aborted valid. Next cycle: state IDLE, gnt=0, done=0, aborted=0, last-served<=winner.
- Requester drops req on seeing done; a req still high in IDLE is re-arbitrated at lower priority than the other requester.
- count never wraps: no decrement below 0; len=2^CNT_W-1 counts full range down to 0.

## Timing
- All outputs registered; no combinational input-to-output paths.
- req high in IDLE at edge k -> gnt, busy, count=len valid after edge k.
- gnt width = len+1 cycles (len RUN + 1 DONE); len=0 -> gnt width 1, done in same cycle as gnt.
- done asserts len cycles after gnt rises; with abort at cycle j of RUN, done asserts the cycle after abort is sampled.
- Minimum grant-to-grant spacing len+2 cycles (one IDLE cycle between intervals).
- Simultaneous req from both in IDLE: exactly one gnt bit; loser served next interval if still requesting.
- rst asserted mid-RUN or DONE: outputs clear immediately, no done pulse; pointer returns to reset value.

## Test plan
- Reset: drive rst low during RUN with count=3 -> gnt, busy, count, done, aborted all 0 without waiting for clk; after release, idle with no req -> outputs stay 0.
- Single request: req=01, len0=5 -> gnt=01 next edge, count 5,4,3,2,1 over RUN, then count=0 with done=01 for one cycle, gnt=00 the cycle after; busy high for 6 cycles.
- Contention: after reset, req=11 held, len0=2, len1=3 -> grants alternate 01,10,01,10 with one idle cycle between; done pulses match grant owner.
- Zero length: req=10, len1=0 -> gnt=10 and done=10 in the same single cycle, count=0, then IDLE.
- Abort: req=01, len0=8, abort pulsed when count=3 -> next cycle done=01, aborted=1, count=0; following cycle gnt=00, aborted=0.
- Full range: len0=15 -> count 15 down to 1 over 15 RUN cycles, then 0 in DONE; no wrap to 15; req0 dropped mid-RUN does not shorten interval.

Source files
------------

// File: rtl/counter_timer_arbiter.sv
// Round-robin owner of a down-counter: grants one of two requesters an interval
// of its programmed length, counts it to zero, then pulses done to the winner.
module counter_timer_arbiter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             aborted_q, aborted_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic             win_c;
  logic [CNT_W-1:0] win_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      count_q   <= '0;
      aborted_q <= 1'b0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      count_q   <= count_d;
      aborted_q <= aborted_d;
      last_q    <= last_d;
      win_q     <= win_d;
    end
  end

  // Under contention the requester that was not served last wins.
  assign win_c   = (req == 2'b11) ? ~last_q : req[1];
  assign win_len = win_c ? len1 : len0;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    count_d   = count_q;
    aborted_d = aborted_q;
    last_d    = last_q;
    win_d     = win_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          win_d   = win_c;
          gnt_d   = {win_c, ~win_c};
          count_d = win_len;
          if (win_len != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            done_d  = {win_c, ~win_c};
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = DONE;
          count_d   = '0;
          aborted_d = 1'b1;
          done_d    = gnt_q;
        end else if (count_q <= ONE) begin
          state_d = DONE;
          count_d = '0;
          done_d  = gnt_q;
        end else begin
          count_d = count_q - ONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        gnt_d     = '0;
        aborted_d = 1'b0;
        last_d    = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign count   = count_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
